// File: rtl/p3_pkg.sv
// Shared definitions for the P3 execute stage: opcodes, flag bit positions,
// memory-op encodings and small opcode decode helpers.
package p3_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WIDE_W = 2 * DATA_W;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned MEM_W  = 2;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned SHA_W  = 4;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [MEM_W-1:0] MEM_NONE  = 2'b00;
  localparam logic [MEM_W-1:0] MEM_LOAD  = 2'b01;
  localparam logic [MEM_W-1:0] MEM_STORE = 2'b10;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_CMP   = 4'd5,
    OP_MOV   = 4'd6,
    OP_NOP7  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SLR   = 4'd9,
    OP_SRL   = 4'd10,
    OP_SRA   = 4'd11,
    OP_IN    = 4'd12,
    OP_OUT   = 4'd13,
    OP_NOP14 = 4'd14,
    OP_HLT   = 4'd15
  } opcode_e;

  // Low two opcode bits of the shift group select the shift kind directly.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SLR = 2'b01,
    SH_SRL = 2'b10,
    SH_SRA = 2'b11
  } shift_kind_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic op_updates_flags(input logic [OP_W-1:0] op);
    return (op <= 4'd6) || ((op >= 4'd8) && (op <= 4'd11));
  endfunction

  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return !((op == 4'd5) || (op == 4'd13) || (op == 4'd15) ||
             (op == 4'd7) || (op == 4'd14));
  endfunction

endpackage

// File: rtl/p3_shift.sv
// Combinational 16-bit shifter/rotator; carry is the last bit shifted out,
// forced to 0 when the amount is zero.
module p3_shift
  import p3_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [SHA_W-1:0]  amount,
  input  shift_kind_e       kind,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [WIDE_W-1:0] wide;

  // Shift inside a double-width word so the outgoing bit lands at a fixed position.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (kind)
      SH_SLL: begin
        wide   = {{DATA_W{1'b0}}, value} << amount;
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      SH_SLR: begin
        wide   = {value, value} << amount;
        result = wide[WIDE_W-1:DATA_W];
        carry  = wide[DATA_W];
      end
      SH_SRL: begin
        wide   = {value, {DATA_W{1'b0}}} >> amount;
        result = wide[WIDE_W-1:DATA_W];
        carry  = wide[DATA_W-1];
      end
      SH_SRA: begin
        wide   = WIDE_W'($signed({value, {DATA_W{1'b0}}}) >>> amount);
        result = wide[WIDE_W-1:DATA_W];
        carry  = wide[DATA_W-1];
      end
      default: begin
        result = value;
      end
    endcase
    if (amount == '0) begin
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/p3_execute.sv
// P3 execute stage: single-cycle ALU pipeline register with sticky flags,
// stall hold and a RUN/HALTED state machine entered by HLT.
module p3_execute
  import p3_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [DATA_W-1:0] alu1,
  input  logic [DATA_W-1:0] alu2,
  input  logic [OP_W-1:0]   opcode,
  input  logic              writereg,
  input  logic [MEM_W-1:0]  memwrite,
  input  logic [REG_W-1:0]  regaddress,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] storedata,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  output logic              writereg_out,
  output logic [MEM_W-1:0]  memwrite_out,
  output logic [REG_W-1:0]  regaddress_out,
  output logic [DATA_W-1:0] address_out,
  output logic [DATA_W-1:0] storedata_out,
  output logic              halted
);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              writereg_q, writereg_d;
  logic [MEM_W-1:0]  memwrite_q, memwrite_d;
  logic [REG_W-1:0]  regaddress_q, regaddress_d;
  logic [DATA_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] storedata_q, storedata_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] sh_res;
  logic              sh_carry;

  p3_shift u_shift (
    .value  (alu1),
    .amount (alu2[SHA_W-1:0]),
    .kind   (shift_kind_e'(opcode[1:0])),
    .result (sh_res),
    .carry  (sh_carry)
  );

  logic              accept;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, keep_result;

  // ALU evaluation and next-state for every pipeline register.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    writereg_d   = writereg_q;
    memwrite_d   = memwrite_q;
    regaddress_d = regaddress_q;
    address_d    = address_q;
    storedata_d  = storedata_q;
    halted_d     = halted_q;
    alu_res      = '0;
    alu_c        = 1'b0;
    alu_v        = 1'b0;
    keep_result  = 1'b0;

    accept = in_valid && !stall && (state_q == ST_RUN);
    sum    = {1'b0, alu1} + {1'b0, alu2};
    diff   = {1'b0, alu1} - {1'b0, alu2};

    case (opcode_e'(opcode))
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (alu1[DATA_W-1] == alu2[DATA_W-1]) && (sum[DATA_W-1] != alu1[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res     = diff[DATA_W-1:0];
        alu_c       = diff[DATA_W];
        alu_v       = (alu1[DATA_W-1] != alu2[DATA_W-1]) && (diff[DATA_W-1] != alu1[DATA_W-1]);
        keep_result = (opcode == OP_CMP);
      end
      OP_AND: alu_res = alu1 & alu2;
      OP_OR:  alu_res = alu1 | alu2;
      OP_XOR: alu_res = alu1 ^ alu2;
      OP_MOV: alu_res = alu2;
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
        alu_res = sh_res;
        alu_c   = sh_carry;
      end
      OP_IN:  alu_res = '0;
      OP_OUT: alu_res = alu1;
      default: keep_result = 1'b1;
    endcase

    // Stall freezes everything; otherwise valid tracks acceptance.
    if (!stall) begin
      out_valid_d = accept;
      if (accept) begin
        if (!keep_result) begin
          result_d = alu_res;
        end
        if (op_updates_flags(opcode)) begin
          flags_d = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
        end
        writereg_d   = writereg && op_writes_reg(opcode);
        memwrite_d   = memwrite;
        regaddress_d = regaddress;
        address_d    = address;
        storedata_d  = storedata;
        if (opcode == OP_HLT) begin
          memwrite_d = MEM_NONE;
          state_d    = ST_HALTED;
        end
      end
    end
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      writereg_q   <= 1'b0;
      memwrite_q   <= MEM_NONE;
      regaddress_q <= '0;
      address_q    <= '0;
      storedata_q  <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      writereg_q   <= writereg_d;
      memwrite_q   <= memwrite_d;
      regaddress_q <= regaddress_d;
      address_q    <= address_d;
      storedata_q  <= storedata_d;
      halted_q     <= halted_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign result         = result_q;
  assign flags          = flags_q;
  assign writereg_out   = writereg_q;
  assign memwrite_out   = memwrite_q;
  assign regaddress_out = regaddress_q;
  assign address_out    = address_q;
  assign storedata_out  = storedata_q;
  assign halted         = halted_q;

endmodule
